btn_conditioner: RTL
====================

# btn_conditioner

- Parametrised, multi-channel pushbutton front end for the game top level.
- Replaces per-button ad-hoc debouncing with one block that, per channel, does:
  - a two-flop synchroniser;
  - counter-based debounce;
  - press/release strobes;
  - optional hold-to-auto-repeat.
- Sits between the board pushbutton pins (ENTER/UP/DOWN/LEFT/RIGHT/pause) and the game FSM; the FSM consumes only single-cycle strobes.

## Interface

Parameters:
- NUM_BTN, 5, number of independent channels.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level change (≥1).
- REPEAT_DELAY, 25000000, cycles from press strobe to first repeat strobe (≥1).
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat strobes (≥1).
- ACTIVE_LOW_MASK, 0, bit i = 1 means pin i reads 0 when pressed.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-low reset.
- btn_in  in  NUM_BTN  raw asynchronous pin levels.
- repeat_en  in  NUM_BTN  per-channel auto-repeat enable, sampled every cycle.
- btn_level  out  NUM_BTN  debounced pressed state, 1 = pressed.
- btn_press  out  NUM_BTN  one-cycle strobe on accepted press.
- btn_release  out  NUM_BTN  one-cycle strobe on accepted release.
- btn_pulse  out  NUM_BTN  btn_press OR auto-repeat strobe; the game FSM's "action" input.

## Operation

- Polarity: raw bit i is XORed with ACTIVE_LOW_MASK[i] before the synchroniser. Everything downstream is active-high.
- Synchroniser: 2 flops per channel.
- Debounce:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever the synchronised level equals btn_level.
  - Otherwise it increments; when it reaches DEBOUNCE_CYCLES, btn_level toggles and the counter clears.
- Strobes:
  - btn_press is high exactly in the first cycle btn_level reads 1.
  - btn_release is high exactly in the first cycle btn_level reads 0.
  - Both strobes are registered and never high together on one channel.
- Repeat FSM per channel: IDLE, HELD, REPEAT.
  - IDLE → HELD on press. The repeat counter loads 0.
  - HELD:
    - Counter increments while repeat_en = 1 and holds at 0 while repeat_en = 0.
    - At REPEAT_DELAY cycles after the press strobe, emit a repeat strobe, go to REPEAT, clear the counter.
  - REPEAT: emit a strobe every REPEAT_PERIOD cycles. If repeat_en drops, go back to HELD with the counter cleared.
  - Any state → IDLE in the cycle btn_release asserts. No strobe is emitted in that cycle, even if a repeat was due.
- btn_pulse = btn_press | repeat strobe.
- Channels are fully independent; any combination of strobes may coincide across channels.

## Timing

- Reset: all outputs are 0, FSMs are IDLE, counters are 0, and synchroniser flops are 0 (not pressed).
  - A button held through reset is debounced afresh after rst rises and yields exactly one btn_press.
  - Reset asserted mid-repeat kills strobes immediately (asynchronous clear).
- Press latency:
  - Hold btn_in stable from just before edge 1.
  - btn_level and btn_press go high after edge DEBOUNCE_CYCLES+2.
  - Release latency is identical.
- Bounce: a pin excursion shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change.
- Repeat timing: with the press strobe in cycle P and repeat_en held at 1, repeat strobes fall in cycles P+REPEAT_DELAY, then +REPEAT_PERIOD each.
- Release wins over a coincident due repeat.
- Counter wrap: no counter exceeds its terminal count; all counters saturate or clear, never wrap.

## Structure

- Shared package btn_cond_pkg holds:
  - state encodings: IDLE = 2'd0, HELD = 2'd1, REPEAT = 2'd2;
  - a counter-width function wrapping $clog2.
- Sub-module btn_channel contains synchroniser, debounce, strobes and repeat FSM for one channel.
  - Parameters: DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD, ACTIVE_LOW.
  - Top level instantiates NUM_BTN copies in a generate loop and slices the vectors.
- Elaboration check: $error if any cycle parameter is below 1.

## Test plan

Bench parameters: NUM_BTN = 5, DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3.

1. Clean press: btn_in[0] 0→1, held 20 cycles, repeat_en = 0 → btn_level[0] and btn_press[0] rise after edge 6; btn_press is exactly 1 cycle wide; btn_pulse equals btn_press; no other bit toggles.
2. Bounce: btn_in[1] toggles 1,0,1,0 with 3-cycle halves, then rests at 0 → btn_level, btn_press and btn_release stay 0 throughout.
3. Auto-repeat: repeat_en[2] = 1, btn_in[2] held 30 cycles after press strobe at P → btn_pulse[2] at P, P+10, P+13, P+16 …; after release, btn_release[2] fires once and the FSM returns to IDLE with no further pulses.
4. Release on due cycle: time the release so btn_release lands on a scheduled repeat cycle → only btn_release asserts; btn_pulse stays 0.
5. Active-low plus simultaneity: ACTIVE_LOW_MASK = 5'b10000; pin 4 driven 1→0 in the same cycle pin 3 goes 0→1 → btn_press[4] and btn_press[3] assert in the same cycle.
6. Reset mid-repeat: rst low for 3 cycles during REPEAT with the button still held → outputs drop to 0 asynchronously; after rst rises, one btn_press arrives 6 edges later, followed by a fresh repeat schedule.

Source files
------------

// File: rtl/btn_cond_pkg.sv
// Shared types and helpers for the pushbutton conditioner: repeat-FSM state
// encoding and counter sizing.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    // Width of a counter that must hold values 0..max_count inclusive.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage : btn_cond_pkg

// File: rtl/btn_channel.sv
// One pushbutton channel: polarity fix, two-flop synchroniser, counter debounce,
// registered press/release strobes and hold-to-auto-repeat FSM.
module btn_channel
    import btn_cond_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 250000,
    parameter int   REPEAT_DELAY    = 25000000,
    parameter int   REPEAT_PERIOD   = 5000000,
    parameter logic ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic pulse_o
);

    localparam int DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = cnt_width(RPT_MAX);

    // Counters toggle/fire one increment early so that the event lands exactly
    // on the Nth cycle and the stored count never reaches the terminal value.
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_LAST   = RPT_W'(REPEAT_PERIOD - 1);

    logic             sync1_q, sync2_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             level_q, level_d;
    logic             press_q, release_q, rep_q, rep_d;
    logic             rise, fall;
    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

    // Synchroniser resets to "not pressed" so a button held through reset
    // is debounced afresh.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pin_i ^ ACTIVE_LOW;
            sync2_q <= sync1_q;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        rep_d     = 1'b0;
        if (fall) begin
            // Release wins: drop to IDLE and suppress any repeat due now.
            state_d   = IDLE;
            rpt_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rpt_cnt_d = '0;
                    if (rise) begin
                        state_d = HELD;
                    end
                end
                HELD: begin
                    if (!repeat_en_i) begin
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == DELAY_LAST) begin
                        rep_d     = 1'b1;
                        state_d   = REPEAT;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!repeat_en_i) begin
                        state_d   = HELD;
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == PER_LAST) begin
                        rep_d     = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rep_q     <= 1'b0;
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= rise;
            release_q <= fall;
            rep_q     <= rep_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign pulse_o   = press_q | rep_q;

endmodule : btn_channel

// File: rtl/btn_conditioner.sv
// Multi-channel pushbutton front end: NUM_BTN independent btn_channel slices
// feeding single-cycle strobes to the game FSM.
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int                 NUM_BTN         = 5,
    parameter int                 DEBOUNCE_CYCLES = 250000,
    parameter int                 REPEAT_DELAY    = 25000000,
    parameter int                 REPEAT_PERIOD   = 5000000,
    parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic [NUM_BTN-1:0] repeat_en,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_pulse
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("btn_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[i])
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .pin_i       (btn_in[i]),
            .repeat_en_i (repeat_en[i]),
            .level_o     (btn_level[i]),
            .press_o     (btn_press[i]),
            .release_o   (btn_release[i]),
            .pulse_o     (btn_pulse[i])
        );
    end

endmodule : btn_conditioner
